bit_serializer: RTL and testbench

//   Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word on a valid/ready

---
 rtl/bit_serializer.sv | 113 +++++++++++
 tb/tb_bit_serializer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock on ser_out, with a frame strobe and a last-bit marker.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_data    parallel word, captured on an accept edge
//   in_valid   upstream has a word
//   in_ready   block can accept a word this cycle (combinational)
//   ser_out    serial data bit (registered)
//   ser_frame  ser_out carries a valid data bit (registered)
//   ser_last   current bit is the final bit of a word (registered)
//   busy       a word is in flight (same as ser_frame)
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic             out_d, frame_d, last_d;
  logic             at_last;
  logic             accept;

  assign at_last  = (cnt == CW'(WIDTH - 1));
  // Ready while idle, or on the final bit so a new word can follow without a gap.
  assign in_ready = !rst && ((state == IDLE) || at_last);
  assign accept   = in_valid && in_ready;
  assign busy     = ser_frame;

  // Next-state and next-output logic.
  // sreg holds only the bits not yet presented; ser_out holds the current bit.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sreg_d  = sreg;
    out_d   = ser_out;
    frame_d = ser_frame;
    last_d  = ser_last;

    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      frame_d = 1'b1;
      last_d  = 1'b0;
      if (MSB_FIRST) begin
        out_d  = in_data[WIDTH-1];
        sreg_d = {in_data[WIDTH-2:0], 1'b0};
      end else begin
        out_d  = in_data[0];
        sreg_d = {1'b0, in_data[WIDTH-1:1]};
      end
    end else if (state == SHIFT) begin
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        sreg_d  = '0;
        out_d   = IDLE_LEVEL;
        frame_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt + CW'(1);
        last_d = (cnt == CW'(WIDTH - 2));
        if (MSB_FIRST) begin
          out_d  = sreg[WIDTH-1];
          sreg_d = {sreg[WIDTH-2:0], 1'b0};
        end else begin
          out_d  = sreg[0];
          sreg_d = {1'b0, sreg[WIDTH-1:1]};
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_frame <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sreg      <= sreg_d;
      ser_out   <= out_d;
      ser_frame <= frame_d;
      ser_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: drives two serializer builds (MSB-first/idle-low and
// LSB-first/idle-high) with shared stimulus and compares every output, every
// cycle, against a queue-of-pending-bits reference model.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ready0, out0, frame0, last0, busy0;
  logic       ready1, out1, frame1, last1, busy1;

  int checks   = 0;
  int failures = 0;

  // Pending bits for each build; element 0 is the bit currently on ser_out.
  logic q0[$];
  logic q1[$];
  logic last_out0, last_out1;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready0), .ser_out(out0), .ser_frame(frame0),
    .ser_last(last0), .busy(busy0)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready1), .ser_out(out1), .ser_frame(frame1),
    .ser_last(last1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, apply inputs, check in_ready,
  // then advance the model across the rising edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    logic exp_ready;
    logic acc;
    @(negedge clk);
    chk("frame0", 8'(frame0), 8'(q0.size() > 0));
    chk("busy0",  8'(busy0),  8'(q0.size() > 0));
    chk("last0",  8'(last0),  8'(q0.size() == 1));
    chk("out0",   8'(out0),   8'((q0.size() > 0) ? q0[0] : 1'b0));
    chk("frame1", 8'(frame1), 8'(q1.size() > 0));
    chk("busy1",  8'(busy1),  8'(q1.size() > 0));
    chk("last1",  8'(last1),  8'(q1.size() == 1));
    chk("out1",   8'(out1),   8'((q1.size() > 0) ? q1[0] : 1'b1));
    last_out0 = out0;
    last_out1 = out1;
    rst      = r;
    in_valid = v;
    in_data  = d;
    #1;
    exp_ready = !r && (q0.size() <= 1);
    chk("ready0", 8'(ready0), 8'(exp_ready));
    chk("ready1", 8'(ready1), 8'(exp_ready));
    @(posedge clk);
    acc = v && exp_ready;
    if (r) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc) begin
        for (int i = 7; i >= 0; i--) q0.push_back(d[i]);
        for (int i = 0; i < 8; i++)  q1.push_back(d[i]);
      end
    end
  endtask

  initial begin
    logic [7:0] w0, w1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);

    // Reset held for two clocks, then released.
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    chk("idle_level1", 8'(out1), 8'h01);

    // Single word 8'hA5; in_data scrambled after the accept edge.
    tick(1'b1, 8'hA5, 1'b0);
    w0 = '0;
    w1 = '0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 8'($urandom), 1'b0);
      w0 = {w0[6:0], last_out0};
      w1 = {last_out1, w1[7:1]};
    end
    chk("word_msb", w0, 8'hA5);
    chk("word_lsb", w1, 8'hA5);
    tick(1'b0, 8'h00, 1'b0);

    // Back-to-back A5 then 3C; valid held with junk data while busy (rejected).
    tick(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 7; k++) tick(1'b1, 8'($urandom), 1'b0);
    tick(1'b1, 8'h3C, 1'b0);
    for (int k = 0; k < 8; k++) tick(1'b0, 8'($urandom), 1'b0);
    tick(1'b0, 8'h00, 1'b0);

    // LSB-first build on 8'h01.
    tick(1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 8'h00, 1'b0);

    // Reset mid-word after 3 bits of F0, then a full FF word.
    tick(1'b1, 8'hF0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h55, 1'b1);
    tick(1'b1, 8'hFF, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 8'h00, 1'b0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++)
      tick($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 49) == 0);
    for (int k = 0; k < 10; k++) tick(1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
